board_led_ctrl: RTL and testbench

BOARD_LED_CTRL -- requirements
Module: board_led_ctrl

---
 rtl/board_led_ctrl_if.sv | 24 ++
 rtl/board_led_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_board_led_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_led_ctrl_if.sv
// Configuration write port for board_led_ctrl: one write at a time, gated by cfg_ready.
interface board_led_ctrl_if #(
    parameter int NUM_RGB  = 4,
    parameter int PWM_BITS = 8
);
    localparam int ADDR_W = (NUM_RGB > 1) ? $clog2(NUM_RGB) : 1;

    logic                cfg_wr;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [1:0]          cfg_mode;
    logic [2:0]          cfg_color;
    logic [PWM_BITS-1:0] cfg_duty;
    logic                cfg_ready;

    modport master (
        output cfg_wr, cfg_addr, cfg_mode, cfg_color, cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_mode, cfg_color, cfg_duty,
        output cfg_ready
    );
endinterface

// File: rtl/board_led_ctrl.sv
// Board LED/button controller: debounced buttons, per-channel RGB modes with period-aligned updates.
// Optional heartbeat output enabled by defining BOARD_LED_CTRL_HEARTBEAT_EN.
module board_led_ctrl #(
    parameter int NUM_BTN          = 4,
    parameter int NUM_RGB          = 4,
    parameter int PWM_BITS         = 8,
    parameter int DEBOUNCE_CYCLES  = 100000,
    parameter int BLINK_CYCLES     = 50000000,
    parameter int HEARTBEAT_CYCLES = 50000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    board_led_ctrl_if.slave    cfg,
    output logic [NUM_RGB-1:0] led_r,
    output logic [NUM_RGB-1:0] led_g,
    output logic [NUM_RGB-1:0] led_b,
    output logic               heartbeat
);
    localparam int ADDR_W = (NUM_RGB > 1) ? $clog2(NUM_RGB) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BL_W   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0]   BL_LAST = BL_W'(BLINK_CYCLES - 1);
    localparam logic [ADDR_W:0]   RGB_LIM = (ADDR_W + 1)'(NUM_RGB);
    localparam logic [1:0] MODE_OFF = 2'd0, MODE_ON = 2'd1, MODE_BLINK = 2'd2;

    if (DEBOUNCE_CYCLES < 1 || BLINK_CYCLES < 1 || HEARTBEAT_CYCLES < 1) begin : g_param_chk
        $error("board_led_ctrl: cycle-count parameters must be at least 1");
    end

    genvar gi;

    // Buttons: 2-flop synchroniser, then a counter that must see a stable mismatch for DEBOUNCE_CYCLES
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic            sync1_reg, sync2_reg, level_reg, press_reg;
            logic [DB_W-1:0] db_cnt_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    level_reg  <= 1'b0;
                    press_reg  <= 1'b0;
                    db_cnt_reg <= '0;
                end else begin
                    sync1_reg <= btn_in[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_LAST) begin
                        level_reg  <= sync2_reg;
                        press_reg  <= sync2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end
            end

            assign btn_level[gi] = level_reg;
            assign btn_press[gi] = press_reg;
        end
    endgenerate

    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [BL_W-1:0]     blink_cnt_reg;
    logic                blink_phase_reg;
    logic                period_end;

    assign period_end = &pwm_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_reg     <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            if (blink_cnt_reg == BL_LAST) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    // Write handshake: a write accepted on a boundary cycle waits for the following boundary
    typedef enum logic {CFG_IDLE, CFG_PEND} cfg_state_t;
    cfg_state_t          state_reg, state_next;
    logic                accept, apply, addr_ok;
    logic [ADDR_W-1:0]   shadow_addr_reg;
    logic [1:0]          shadow_mode_reg;
    logic [2:0]          shadow_color_reg;
    logic [PWM_BITS-1:0] shadow_duty_reg;

    assign addr_ok       = ({1'b0, cfg.cfg_addr} < RGB_LIM);
    assign cfg.cfg_ready = (state_reg == CFG_IDLE);

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        apply      = 1'b0;
        case (state_reg)
            CFG_IDLE: begin
                if (cfg.cfg_wr && addr_ok) begin
                    accept     = 1'b1;
                    state_next = CFG_PEND;
                end
            end
            CFG_PEND: begin
                if (period_end) begin
                    apply      = 1'b1;
                    state_next = CFG_IDLE;
                end
            end
            default: state_next = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= CFG_IDLE;
            shadow_addr_reg  <= '0;
            shadow_mode_reg  <= MODE_OFF;
            shadow_color_reg <= '0;
            shadow_duty_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                shadow_addr_reg  <= cfg.cfg_addr;
                shadow_mode_reg  <= cfg.cfg_mode;
                shadow_color_reg <= cfg.cfg_color;
                shadow_duty_reg  <= cfg.cfg_duty;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_RGB; gi++) begin : g_ch
            logic [1:0]          mode_reg;
            logic [2:0]          color_reg;
            logic [PWM_BITS-1:0] duty_reg;
            logic                r_reg, g_reg, b_reg;
            logic                drive;

            always_comb begin
                drive = 1'b0;
                case (mode_reg)
                    MODE_OFF:   drive = 1'b0;
                    MODE_ON:    drive = 1'b1;
                    MODE_BLINK: drive = blink_phase_reg;
                    default:    drive = (pwm_cnt_reg < duty_reg);
                endcase
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    mode_reg  <= MODE_OFF;
                    color_reg <= '0;
                    duty_reg  <= '0;
                    r_reg     <= 1'b0;
                    g_reg     <= 1'b0;
                    b_reg     <= 1'b0;
                end else begin
                    if (apply && shadow_addr_reg == ADDR_W'(gi)) begin
                        mode_reg  <= shadow_mode_reg;
                        color_reg <= shadow_color_reg;
                        duty_reg  <= shadow_duty_reg;
                    end
                    r_reg <= color_reg[2] & drive;
                    g_reg <= color_reg[1] & drive;
                    b_reg <= color_reg[0] & drive;
                end
            end

            assign led_r[gi] = r_reg;
            assign led_g[gi] = g_reg;
            assign led_b[gi] = b_reg;
        end
    endgenerate

`ifdef BOARD_LED_CTRL_HEARTBEAT_EN
    localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);
    logic [HB_W-1:0] hb_cnt_reg;
    logic            hb_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_cnt_reg <= '0;
            hb_reg     <= 1'b0;
        end else if (hb_cnt_reg == HB_LAST) begin
            hb_cnt_reg <= '0;
            hb_reg     <= ~hb_reg;
        end else begin
            hb_cnt_reg <= hb_cnt_reg + 1'b1;
        end
    end

    assign heartbeat = hb_reg;
`else
    assign heartbeat = 1'b0;
`endif
endmodule

// File: tb/tb_board_led_ctrl.sv
// Bench for board_led_ctrl: table-driven channel writes with a scoreboard, plus debounce,
// handshake, boundary, bad-address, blink/heartbeat and reset-with-pending sequences.
module tb_board_led_ctrl;
    localparam int NUM_BTN  = 4;
    localparam int NUM_RGB  = 3;
    localparam int PWM_BITS = 4;
    localparam int DEB      = 8;
    localparam int BLINK    = 5;
    localparam int HB       = 7;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NUM_BTN-1:0] btn_in = '0;
    logic [NUM_BTN-1:0] btn_level, btn_press;
    logic [NUM_RGB-1:0] led_r, led_g, led_b;
    logic               heartbeat;

    board_led_ctrl_if #(.NUM_RGB(NUM_RGB), .PWM_BITS(PWM_BITS)) cfg_bus ();

    board_led_ctrl #(
        .NUM_BTN(NUM_BTN), .NUM_RGB(NUM_RGB), .PWM_BITS(PWM_BITS),
        .DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLINK), .HEARTBEAT_CYCLES(HB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .btn_level(btn_level),
        .btn_press(btn_press), .cfg(cfg_bus), .led_r(led_r), .led_g(led_g),
        .led_b(led_b), .heartbeat(heartbeat)
    );

    always #5 clk = ~clk;

    // Period phase and edge count since reset release, used as the timing reference
    logic [3:0] tb_cnt;
    int         tb_total;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tb_cnt   <= '0;
            tb_total <= 0;
        end else begin
            tb_cnt   <= tb_cnt + 4'd1;
            tb_total <= tb_total + 1;
        end
    end

    typedef struct {
        logic [1:0] addr;
        logic [1:0] mode;
        logic [2:0] color;
        logic [3:0] duty;
        int         exp_r;
        int         exp_g;
        int         exp_b;
    } vec_t;

    vec_t vecs [7];
    vec_t sb [$];
    int   r_cnt [NUM_RGB];
    int   g_cnt [NUM_RGB];
    int   b_cnt [NUM_RGB];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_write(input logic [1:0] addr, input logic [1:0] mode,
                               input logic [2:0] color, input logic [3:0] duty);
        cfg_bus.cfg_wr    = 1'b1;
        cfg_bus.cfg_addr  = addr;
        cfg_bus.cfg_mode  = mode;
        cfg_bus.cfg_color = color;
        cfg_bus.cfg_duty  = duty;
        $display("write ch%0d mode %0d color %b duty %0d phase %0d", addr, mode, color, duty, tb_cnt);
        @(posedge clk);
        @(negedge clk);
        cfg_bus.cfg_wr = 1'b0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 40 && cfg_bus.cfg_ready !== 1'b1; k++) @(negedge clk);
        check("ready_timeout", 32'(cfg_bus.cfg_ready), 32'd1);
    endtask

    task automatic wait_phase(input logic [3:0] ph);
        for (int k = 0; k < 20 && tb_cnt != ph; k++) @(negedge clk);
    endtask

    task automatic measure_window();
        for (int c = 0; c < NUM_RGB; c++) begin
            r_cnt[c] = 0; g_cnt[c] = 0; b_cnt[c] = 0;
        end
        for (int s = 0; s < 16; s++) begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_RGB; c++) begin
                r_cnt[c] += int'(led_r[c]);
                g_cnt[c] += int'(led_g[c]);
                b_cnt[c] += int'(led_b[c]);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_pop();
        vec_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got 0 entries expected at least 1");
        end else begin
            e = sb.pop_front();
            check("win_r", 32'(r_cnt[e.addr]), 32'(e.exp_r));
            check("win_g", 32'(g_cnt[e.addr]), 32'(e.exp_g));
            check("win_b", 32'(b_cnt[e.addr]), 32'(e.exp_b));
            $display("window ch%0d r %0d g %0d b %0d", e.addr, r_cnt[e.addr], g_cnt[e.addr], b_cnt[e.addr]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_bit, exp_hb;
        int   n;

        vecs[0] = '{2'd1, 2'd3, 3'b100, 4'd4,  4,  0,  0};
        vecs[1] = '{2'd0, 2'd1, 3'b101, 4'd0,  16, 0,  16};
        vecs[2] = '{2'd2, 2'd3, 3'b011, 4'd0,  0,  0,  0};
        vecs[3] = '{2'd2, 2'd3, 3'b111, 4'd15, 15, 15, 15};
        vecs[4] = '{2'd0, 2'd0, 3'b111, 4'd9,  0,  0,  0};
        vecs[5] = '{2'd1, 2'd3, 3'b010, 4'd1,  0,  1,  0};
        vecs[6] = '{2'd0, 2'd3, 3'b110, 4'd8,  8,  8,  0};

        cfg_bus.cfg_wr    = 1'b0;
        cfg_bus.cfg_addr  = '0;
        cfg_bus.cfg_mode  = '0;
        cfg_bus.cfg_color = '0;
        cfg_bus.cfg_duty  = '0;

        repeat (3) @(negedge clk);
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_press", 32'(btn_press), 32'd0);
        check("rst_leds", 32'({led_r, led_g, led_b}), 32'd0);
        check("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        check("rst_hb", 32'(heartbeat), 32'd0);
        reset_n = 1'b1;

        // Bad address: channel 3 does not exist
        @(negedge clk);
        drive_write(2'd3, 2'd1, 3'b111, 4'd0);
        for (int k = 0; k < 20; k++) begin
            check("bad_ready", 32'(cfg_bus.cfg_ready), 32'd1);
            check("bad_leds", 32'({led_r, led_g, led_b}), 32'd0);
            @(negedge clk);
        end

        // Debounce: bounce every 3 cycles ending low, then hold high
        for (int p = 0; p < 6; p++) begin
            btn_in[0] = (p % 2 == 0);
            repeat (3) begin
                @(posedge clk);
                #1;
                check("db_bounce_lvl", 32'(btn_level), 32'd0);
                check("db_bounce_prs", 32'(btn_press), 32'd0);
            end
        end
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check("db_rise_lvl", 32'(btn_level), (k >= 10) ? 32'd1 : 32'd0);
            check("db_rise_prs", 32'(btn_press), (k == 10) ? 32'd1 : 32'd0);
        end
        $display("button 0 press sequence done");
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check("db_fall_lvl", 32'(btn_level), (k < 10) ? 32'd1 : 32'd0);
            check("db_fall_prs", 32'(btn_press), 32'd0);
        end
        $display("button 0 release sequence done");
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            wait_ready();
            sb.push_back(vecs[i]);
            drive_write(vecs[i].addr, vecs[i].mode, vecs[i].color, vecs[i].duty);
            wait_ready();
            measure_window();
            check_pop();
        end

        // Mid-period write; a second write while not ready must be dropped
        wait_ready();
        wait_phase(4'd5);
        sb.push_back('{2'd1, 2'd3, 3'b100, 4'd4, 4, 0, 0});
        cfg_bus.cfg_wr    = 1'b1;
        cfg_bus.cfg_addr  = 2'd1;
        cfg_bus.cfg_mode  = 2'd3;
        cfg_bus.cfg_color = 3'b100;
        cfg_bus.cfg_duty  = 4'd4;
        $display("write ch1 mode 3 color 100 duty 4 phase %0d", tb_cnt);
        @(posedge clk);
        @(negedge clk);
        check("hs_drop", 32'(cfg_bus.cfg_ready), 32'd0);
        cfg_bus.cfg_addr  = 2'd2;
        cfg_bus.cfg_mode  = 2'd0;
        cfg_bus.cfg_color = 3'b111;
        $display("write ch2 mode 0 while busy phase %0d", tb_cnt);
        @(posedge clk);
        @(negedge clk);
        cfg_bus.cfg_wr = 1'b0;
        for (int k = 0; k < 40; k++) begin
            exp_bit = (tb_cnt == 4'd0);
            check("hs_ready", 32'(cfg_bus.cfg_ready), 32'(exp_bit));
            if (exp_bit) break;
            @(negedge clk);
        end
        measure_window();
        check_pop();
        check("hs_ignored_r", 32'(r_cnt[2]), 32'd15);
        check("hs_ignored_g", 32'(g_cnt[2]), 32'd15);
        check("hs_ignored_b", 32'(b_cnt[2]), 32'd15);

        // Write accepted on the boundary cycle waits a full extra period
        wait_phase(4'd15);
        sb.push_back('{2'd0, 2'd1, 3'b010, 4'd0, 0, 16, 0});
        drive_write(2'd0, 2'd1, 3'b010, 4'd0);
        for (int k = 0; k < 16; k++) begin
            check("bnd_busy", 32'(cfg_bus.cfg_ready), 32'd0);
            @(negedge clk);
        end
        check("bnd_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        measure_window();
        check_pop();

        // Blink on ch0, all colours, with heartbeat
        drive_write(2'd0, 2'd2, 3'b111, 4'd0);
        wait_ready();
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            n = tb_total;
            exp_bit = ((n - 1) / BLINK) % 2 == 1;
`ifdef BOARD_LED_CTRL_HEARTBEAT_EN
            exp_hb = (n / HB) % 2 == 1;
`else
            exp_hb = 1'b0;
`endif
            check("blink_r", 32'(led_r[0]), 32'(exp_bit));
            check("blink_g", 32'(led_g[0]), 32'(exp_bit));
            check("blink_b", 32'(led_b[0]), 32'(exp_bit));
            check("heartbeat", 32'(heartbeat), 32'(exp_hb));
        end
        $display("blink/heartbeat window done");
        @(negedge clk);

        // Reset with a write pending
        wait_phase(4'd3);
        drive_write(2'd2, 2'd1, 3'b111, 4'd0);
        check("pend_busy", 32'(cfg_bus.cfg_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("prst_leds", 32'({led_r, led_g, led_b}), 32'd0);
        check("prst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        check("prst_hb", 32'(heartbeat), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        $display("reset released with write discarded");
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("post_leds", 32'({led_r, led_g, led_b}), 32'd0);
            check("post_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
